// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: M/W forwarding, load-use stall, redirect flush, and a
// register scoreboard tracking long-latency ops that complete out of band.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int MAX_PEND = 4,
  parameter int CW       = 3,
  localparam int AW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] RdD,
  input  logic          LongD,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic [1:0]    ResultSrcE,
  input  logic [1:0]    PCSrcE,
  input  logic          LongIssueE,
  input  logic          LongDone,
  input  logic [AW-1:0] LongRd,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          SbFull,
  output logic          SbErr
);

  logic [NREG-1:0] pend, pend_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            err;

  logic            done_bad, done_ok;
  logic            lu, raw, waw, full, sb, redirect;
  logic [1:0]      fwd_a, fwd_b;
  logic [CW:0]     occ_lhs, occ_rhs;

  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == Rs1E)      fwd_a = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == Rs1E) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == Rs2E)      fwd_b = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == Rs2E) fwd_b = 2'b01;
  end

  // A long op still sitting in E is not yet in pend, so its D-stage consumers
  // are held the same way a load-use would be.
  assign lu = RdE != '0 && (RdE == Rs1D || RdE == Rs2D) &&
              (ResultSrcE == 2'b01 || LongIssueE);

  assign raw = pend[Rs1D] || pend[Rs2D];
  assign waw = RdD != '0 && pend[RdD];

  // Occupancy after this edge compared without going negative.
  assign occ_lhs = {1'b0, cnt} + (CW+1)'(LongIssueE);
  assign occ_rhs = (CW+1)'(MAX_PEND) + (CW+1)'(LongDone);
  assign full    = LongD && (occ_lhs >= occ_rhs);

  assign sb       = raw || waw || full;
  assign redirect = PCSrcE != 2'b00;

  always_comb begin
    if (rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      SbFull    = 1'b0;
      SbErr     = 1'b0;
    end else begin
      StallF    = (lu || sb) && !redirect;
      StallD    = (lu || sb) && !redirect;
      FlushD    = redirect;
      FlushE    = lu || sb || redirect;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      SbFull    = cnt == CW'(MAX_PEND);
      SbErr     = err;
    end
  end

  assign done_bad = LongDone && ((LongRd != '0 && !pend[LongRd]) || cnt == '0);
  assign done_ok  = LongDone && !done_bad;

  // Clear before set, so an issue and a completion to one register keep it pending.
  always_comb begin
    pend_n = pend;
    if (done_ok)                   pend_n[LongRd] = 1'b0;
    if (LongIssueE && RdE != '0)   pend_n[RdE]    = 1'b1;
    pend_n[0] = 1'b0;

    cnt_n = cnt;
    if (LongIssueE && !done_ok && cnt != CW'(MAX_PEND))
      cnt_n = cnt + CW'(1);
    else if (done_ok && !LongIssueE && cnt != '0)
      cnt_n = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      pend <= pend_n;
      cnt  <= cnt_n;
      if (done_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: table of combinational vectors, directed
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_hazard_scoreboard;
  localparam int MAX_PEND = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRd;
  logic       LongD, RegWriteM, RegWriteW, LongIssueE, LongDone;
  logic [1:0] ResultSrcE, PCSrcE;
  logic       StallF, StallD, FlushD, FlushE, SbFull, SbErr;
  logic [1:0] ForwardAE, ForwardBE;

  hazard_scoreboard #(.NREG(32), .MAX_PEND(MAX_PEND), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongD(LongD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .LongIssueE(LongIssueE), .LongDone(LongDone), .LongRd(LongRd),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .SbFull(SbFull), .SbErr(SbErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: which registers await a long result, how many unit slots are busy.
  bit pend_m[32];
  int cnt_m;
  bit err_m;

  typedef struct {
    int rs1d, rs2d, rdd, longd, rs1e, rs2e, rde, rdm, rdw, regwm, regww, ressrc, pcsrc;
    int sf, fd, fe, fa, fb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, SbFull, SbErr};
  endfunction

  function automatic int fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  function automatic logic [9:0] model_vec();
    bit lu, raw, waw, full, stall, fd, fe;
    if (rst) return 10'b0011000000;
    lu   = RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && (ResultSrcE == 2'b01 || LongIssueE);
    raw  = pend_m[Rs1D] || pend_m[Rs2D];
    waw  = RdD != 0 && pend_m[RdD];
    full = LongD && (cnt_m + int'(LongIssueE) - int'(LongDone) >= MAX_PEND);
    fd    = PCSrcE != 0;
    stall = (lu || raw || waw || full) && !fd;
    fe    = lu || raw || waw || full || fd;
    return {stall, stall, fd, fe, 2'(fwd(Rs1E)), 2'(fwd(Rs2E)), cnt_m == MAX_PEND, err_m};
  endfunction

  task automatic model_step();
    bit bad;
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 0;
      cnt_m = 0;
      err_m = 0;
      return;
    end
    bad = LongDone && ((LongRd != 0 && !pend_m[LongRd]) || cnt_m == 0);
    if (bad) err_m = 1;
    if (LongDone && !bad) begin
      pend_m[LongRd] = 0;
      cnt_m--;
    end
    if (LongIssueE) begin
      if (RdE != 0) pend_m[RdE] = 1;
      cnt_m++;
    end
    if (cnt_m > MAX_PEND) cnt_m = MAX_PEND;
    if (cnt_m < 0) cnt_m = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRd} = '0;
    {LongD, RegWriteM, RegWriteW, LongIssueE, LongDone} = '0;
    ResultSrcE = 2'b00;
    PCSrcE = 2'b00;
  endtask

  task automatic issue(input int rd);
    idle();
    LongIssueE = 1'b1;
    RdE = 5'(rd);
    cycle();
  endtask

  task automatic done(input int rd);
    idle();
    LongDone = 1'b1;
    LongRd = 5'(rd);
    cycle();
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [9:0] e;
    int plist[$];

    // rs1d rs2d rdd longd rs1e rs2e rde rdm rdw wm ww rsrc pcsrc | sf fd fe fa fb
    tbl.push_back('{0,0,0,0, 5,0, 0, 5,0, 1,0, 0,0,  0,0,0, 2,0});
    tbl.push_back('{0,0,0,0, 5,0, 0, 0,5, 0,1, 0,0,  0,0,0, 1,0});
    tbl.push_back('{0,0,0,0, 0,0, 0, 0,0, 1,0, 0,0,  0,0,0, 0,0});
    tbl.push_back('{0,0,0,0, 5,5, 0, 5,5, 1,1, 0,0,  0,0,0, 2,2});
    tbl.push_back('{0,0,0,0, 5,6, 0, 6,5, 1,1, 0,0,  0,0,0, 1,2});
    tbl.push_back('{0,0,0,0, 5,0, 0, 5,0, 0,0, 0,0,  0,0,0, 0,0});
    tbl.push_back('{0,3,0,0, 0,0, 3, 0,0, 0,0, 1,0,  1,0,1, 0,0});
    tbl.push_back('{3,0,0,0, 0,0, 3, 0,0, 0,0, 1,0,  1,0,1, 0,0});
    tbl.push_back('{4,0,0,0, 0,0, 3, 0,0, 0,0, 1,0,  0,0,0, 0,0});
    tbl.push_back('{3,0,0,0, 0,0, 3, 0,0, 0,0, 2,0,  0,0,0, 0,0});
    tbl.push_back('{0,0,0,0, 0,0, 0, 0,0, 0,0, 1,0,  0,0,0, 0,0});
    tbl.push_back('{0,0,0,0, 0,0, 0, 0,0, 0,0, 0,1,  0,1,1, 0,0});
    tbl.push_back('{3,0,0,0, 0,0, 3, 0,0, 0,0, 1,2,  0,1,1, 0,0});

    // reset state, with a forwarding match present that must be masked
    idle();
    rst = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    #1;
    chk("rst_outputs", dut_vec(), 10'b0011000000);
    cycle();
    cycle();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_idle", dut_vec(), 10'b0000000000);

    foreach (tbl[i]) begin
      v = tbl[i];
      idle();
      Rs1D = 5'(v.rs1d); Rs2D = 5'(v.rs2d); RdD = 5'(v.rdd); LongD = 1'(v.longd);
      Rs1E = 5'(v.rs1e); Rs2E = 5'(v.rs2e); RdE = 5'(v.rde);
      RdM = 5'(v.rdm); RdW = 5'(v.rdw);
      RegWriteM = 1'(v.regwm); RegWriteW = 1'(v.regww);
      ResultSrcE = 2'(v.ressrc); PCSrcE = 2'(v.pcsrc);
      e = {1'(v.sf), 1'(v.sf), 1'(v.fd), 1'(v.fe), 2'(v.fa), 2'(v.fb), 2'b00};
      #1;
      chk($sformatf("table[%0d]", i), dut_vec(), e);
      cycle();
    end

    // load-use holds one cycle, then clears once the load has moved on
    idle(); ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3; #1;
    chk("lu_stall", {StallF, StallD, FlushE}, 3'b111);
    cycle();
    idle(); Rs1D = 5'd3; #1;
    chk("lu_release", {StallF, StallD, FlushE}, 3'b000);

    // long op to x7: D consumer held until the cycle after completion
    issue(7);
    idle(); Rs1D = 5'd7; #1;
    chk("long_hold1", {StallF, StallD, FlushE}, 3'b111);
    cycle();
    #1;
    chk("long_hold2", {StallF, StallD, FlushE}, 3'b111);
    LongDone = 1'b1; LongRd = 5'd7; #1;
    chk("long_done_cycle", {StallF, StallD, FlushE}, 3'b111);
    cycle();
    LongDone = 1'b0; #1;
    chk("long_release", {StallF, StallD, FlushE}, 3'b000);

    // issue and completion to one register in one cycle leave it pending
    issue(13);
    idle(); LongIssueE = 1'b1; RdE = 5'd13; LongDone = 1'b1; LongRd = 5'd13;
    cycle();
    idle(); Rs2D = 5'd13; #1;
    chk("issue_done_same_reg", StallF, 1'b1);
    done(13);

    // redirect overrides a scoreboard stall
    issue(8);
    idle(); Rs1D = 5'd8; PCSrcE = 2'b01; #1;
    chk("redirect_over_sb", {StallF, StallD, FlushD, FlushE}, 4'b0011);
    done(8);

    // fill the unit, LongD stalls on occupancy, one completion lets it through
    for (int r = 1; r <= 4; r++) issue(r);
    idle(); #1;
    chk("full_flag", SbFull, 1'b1);
    LongD = 1'b1; RdD = 5'd10; Rs1D = 5'd11; #1;
    chk("full_stall", {StallF, FlushE}, 2'b11);
    LongDone = 1'b1; LongRd = 5'd1; #1;
    chk("full_proceeds", {StallF, FlushE}, 2'b00);
    cycle();
    idle(); #1;
    chk("full_flag_drop", SbFull, 1'b0);
    issue(5);
    issue(6);                       // occupancy saturates rather than wrapping
    idle(); #1;
    chk("full_saturate", SbFull, 1'b1);
    for (int r = 2; r <= 5; r++) done(r);
    idle(); #1;
    chk("drained", {SbFull, SbErr}, 2'b00);
    done(6);                        // nothing outstanding by count: error, x6 kept
    idle(); Rs1D = 5'd6; #1;
    chk("err_cnt_zero", {SbErr, StallF}, 2'b11);

    // reset mid-stall drops all pending state
    rst = 1'b1; #1;
    chk("rst_mid_stall", {StallF, FlushD, SbErr}, 3'b010);
    cycle();
    rst = 1'b0; #1;
    chk("after_rst_no_stall", {StallF, SbErr, SbFull}, 3'b000);

    // completion for a non-pending register while another is outstanding
    issue(12);
    done(9);
    idle(); Rs1D = 5'd12; #1;
    chk("err_not_pending", {SbErr, StallF}, 2'b11);
    cycle();
    idle(); #1;
    chk("err_sticky", SbErr, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(); Rs1D = 5'd12; #1;
    chk("rst_clears_pend", {StallF, SbErr}, 2'b00);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 199) == 0);
      Rs1D = 5'($urandom_range(0, 7));
      Rs2D = 5'($urandom_range(0, 7));
      RdD  = 5'($urandom_range(0, 7));
      LongD = 1'($urandom_range(0, 1));
      Rs1E = 5'($urandom_range(0, 7));
      Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7));
      RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      LongIssueE = (cnt_m < MAX_PEND) && ($urandom_range(0, 2) == 0);
      if (cnt_m > 0 && $urandom_range(0, 2) == 0) begin
        plist.delete();
        for (int r = 1; r < 32; r++) if (pend_m[r]) plist.push_back(r);
        LongDone = 1'b1;
        LongRd = (plist.size() > 0) ? 5'(plist[$urandom_range(0, plist.size() - 1)]) : 5'd0;
      end
      #1;
      chk($sformatf("random[%0d]", n), dut_vec(), model_vec());
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
